// File: rtl/mem_if_pkg.sv
// Shared types for the MEM-stage memory responder.
// State encoding, operation codes and wait-counter width.
package mem_if_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_core.sv
// Single-port synchronous word array.
// Write and registered read share one edge.
module ram_core #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (we) mem_q[idx] <= wdata;
    if (re) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Handshaked multi-cycle data-memory slave for the MEM stage.
// Captures a request, waits, commits, then pulses Ready.
module ram_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  errMisaligned
);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic op_q, op_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic mis_q, mis_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic err_q, err_d;

  logic req;
  logic enter_resp;
  logic c_op;
  logic c_mis;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic ram_we;
  logic ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic unused_addr;

  assign req = Read | Write;
  assign unused_addr = ^Address[31:ADDR_WIDTH+2];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = Write ? OP_WRITE : OP_READ;
          idx_d   = Address[ADDR_WIDTH+1:2];
          wdata_d = writeData;
          mis_d   = (Address[1:0] != 2'b00);
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else cnt_d = cnt_q - 1'b1;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Zero wait states commit straight from IDLE, so use live inputs there.
  always_comb begin
    c_op    = op_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_mis   = mis_q;
    if (state_q == S_IDLE) begin
      c_op    = op_d;
      c_idx   = idx_d;
      c_wdata = wdata_d;
      c_mis   = mis_d;
    end
  end

  assign enter_resp = (state_d == S_RESP)
                   && (state_q != S_RESP)
                   && !Reset;
  assign ram_we = enter_resp && (c_op == OP_WRITE) && !c_mis;
  assign ram_re = enter_resp && (c_op == OP_READ) && !c_mis;

  always_comb begin
    ready_d = (state_q == S_RESP);
    busy_d  = (state_q != S_IDLE);
    err_d   = (state_q == S_RESP) && mis_q;
    data_d  = data_q;
    if (state_q == S_RESP && op_q == OP_READ && !mis_q)
      data_d = ram_rdata;
  end

  ram_core #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .CLK  (CLK),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (c_idx),
    .wdata(c_wdata),
    .rdata(ram_rdata)
  );

  assign dataOut       = data_q;
  assign Ready         = ready_q;
  assign Busy          = busy_q;
  assign errMisaligned = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: vector table, scoreboard, corner sequences.
// A second instance covers the zero-wait-state configuration.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wd;
  logic [31:0] dout;
  logic        rdy, bsy, err;

  logic        rd0, wr0;
  logic [31:0] addr0, wd0;
  logic [31:0] dout0;
  logic        rdy0, bsy0, err0;

  always #5 clk = ~clk;

  ram_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .Reset(rst), .Read(rd), .Write(wr),
    .Address(addr), .writeData(wd), .dataOut(dout),
    .Ready(rdy), .Busy(bsy), .errMisaligned(err)
  );

  ram_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .Reset(rst), .Read(rd0), .Write(wr0),
    .Address(addr0), .writeData(wd0), .dataOut(dout0),
    .Ready(rdy0), .Busy(bsy0), .errMisaligned(err0)
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  exp_t sb[$];
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", dout, e.data);
        chk("resp_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic do_req(input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    int n;
    int busy_n;
    n = 0;
    busy_n = 0;
    @(negedge clk);
    rd = r; wr = w; addr = a; wd = d;
    @(posedge clk); #1;
    rd = 0; wr = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (bsy) busy_n++;
    end while (!rdy && n < 20);
    if (n >= 20) chk("ready_timeout", 32'd1, 32'd0);
    else begin
      chk("latency", n, 32'd3);
      chk("busy_cycles", busy_n, 32'd3);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h20,  32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h420, 32'h0,        32'h12345678, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h13,  32'h55555555, 32'h12345678, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h11,  32'h0,        32'hDEADBEEF, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 32'h04,  32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 32'h04,  32'h0,        32'h0BADF00D, 1'b0};

    rst = 1; rd = 0; wr = 0; addr = 0; wd = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_outs", {dout, 1'b0} | {31'd0, rdy, bsy | err}, 33'd0);
    end

    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.data = tbl[i].exp_data;
      e.err  = tbl[i].exp_err;
      sb.push_back(e);
      do_req(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
    end

    // Abort a write in WAIT; nothing is pushed, so a Ready would fail.
    @(negedge clk);
    wr = 1; addr = 32'h04; wd = 32'hAAAA5555;
    @(posedge clk); #1;
    wr = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_dout", dout, 32'h0);
    chk("rst_flags", {29'd0, rdy, bsy, err}, 32'h0);
    repeat (5) @(posedge clk);
    #1 chk("rst_busy_after", {31'd0, bsy}, 32'h0);
    begin
      exp_t e;
      e.data = 32'h0BADF00D;
      e.err  = 1'b0;
      sb.push_back(e);
      do_req(1'b1, 1'b0, 32'h04, 32'h0);
    end

    // Zero wait states with a request held high continuously.
    @(negedge clk);
    wr0 = 1; addr0 = 32'h08; wd0 = 32'h0000CAFE;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("w0_ready", {31'd0, rdy0}, {31'd0, i[0]});
      chk("w0_busy_eq_ready", {31'd0, bsy0}, {31'd0, rdy0});
    end
    @(negedge clk); wr0 = 0;

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
